// File: rtl/video_sdram_arbiter.sv
// Two-requester arbiter for the SDRAM controller command port: video burst reads
// (priority) and single-word writes (promoted once they have waited WR_MAX_WAIT cycles).
module video_sdram_arbiter #(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned WR_MAX_WAIT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  output logic              vid_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_we,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              err_stray
);

  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned WAIT_W = $clog2(WR_MAX_WAIT + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WR_MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE,
    VID_CMD,
    VID_DATA,
    WR_CMD
  } state_t;

  state_t            state;
  logic [BEAT_W-1:0] beat_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              starve;
  logic              beat;

  always_comb begin
    starve     = (wait_cnt >= WAIT_LIMIT);
    beat       = (state == VID_DATA) && mem_rvalid;
    vid_gnt    = mem_cmd_valid && mem_cmd_ready && (state == VID_CMD);
    wr_gnt     = mem_cmd_valid && mem_cmd_ready && (state == WR_CMD);
    vid_rvalid = beat;
    vid_rdata  = beat ? mem_rdata : '0;
    vid_done   = beat && (beat_cnt == LAST_BEAT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      mem_cmd_valid <= 1'b0;
      mem_cmd_we    <= 1'b0;
      mem_cmd_addr  <= '0;
      mem_wdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_req && (starve || !vid_req)) begin
            state         <= WR_CMD;
            mem_cmd_valid <= 1'b1;
            mem_cmd_we    <= 1'b1;
            mem_cmd_addr  <= wr_addr;
            mem_wdata     <= wr_data;
          end else if (vid_req) begin
            state         <= VID_CMD;
            mem_cmd_valid <= 1'b1;
            mem_cmd_we    <= 1'b0;
            mem_cmd_addr  <= vid_addr;
          end
        end
        VID_CMD: begin
          if (mem_cmd_ready) begin
            state         <= VID_DATA;
            mem_cmd_valid <= 1'b0;
            beat_cnt      <= '0;
          end
        end
        VID_DATA: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) begin
              state <= IDLE;
            end
          end
        end
        WR_CMD: begin
          if (mem_cmd_ready) begin
            state         <= IDLE;
            mem_cmd_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The wait counter keeps running during the IDLE decision cycle and video
  // phases, holds while the write command itself is waiting, and saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!wr_req || wr_gnt) begin
      wait_cnt <= '0;
    end else if ((state != WR_CMD) && !starve) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_stray <= 1'b0;
    end else if (mem_rvalid && (state != VID_DATA)) begin
      err_stray <= 1'b1;
    end
  end

endmodule

// File: tb/tb_video_sdram_arbiter.sv
module tb_video_sdram_arbiter;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int BL     = 8;
  localparam int WMAX   = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              vid_req, wr_req, mem_cmd_ready, mem_rvalid;
  logic [ADDR_W-1:0] vid_addr, wr_addr, mem_cmd_addr;
  logic [DATA_W-1:0] wr_data, mem_rdata, vid_rdata, mem_wdata;
  logic              vid_gnt, vid_rvalid, vid_done, wr_gnt;
  logic              mem_cmd_valid, mem_cmd_we, err_stray;

  video_sdram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL), .WR_MAX_WAIT(WMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid), .vid_done(vid_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .err_stray(err_stray)
  );

  always #5 clk = ~clk;

  // Reference model: an outstanding-command queue plus a remaining-beat count.
  typedef struct {
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  cmd_t cmd_q[$];
  int   beats_left, wait_cycles, cmd_age, ready_after;
  bit   err_m;

  int                vid_pct, wr_pct, rv_pct, fixed_delay, stray_n;
  bit                vid_hold, wr_hold, vid_once, wr_once, seq_mode, vid_fixed, wr_fixed;
  logic [DATA_W-1:0] seq_base, wr_fixed_data;
  logic [ADDR_W-1:0] vid_fixed_addr, wr_fixed_addr;

  int                cyc, n_cmp, n_bad, n_vgnt, n_wgnt, n_rv, n_done, n_wvalid;
  int                gnt_cyc_v, gnt_cyc_w, done_cyc, req_cyc_v;
  logic [DATA_W-1:0] last_rdata, done_rdata, gnt_wdata_w;
  logic [ADDR_W-1:0] gnt_addr_v, gnt_addr_w;
  bit                exp_vgnt_q, exp_wgnt_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    cmd_q.delete();
    beats_left  = 0;
    wait_cycles = 0;
    cmd_age     = 0;
    err_m       = 1'b0;
  endtask

  task automatic new_cmd(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cmd_t c;
    c.we = we; c.addr = a; c.data = d;
    cmd_q.push_back(c);
    cmd_age     = 0;
    ready_after = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
  endtask

  task automatic compare();
    bit pend, ewe, egv, egw, erv, edone;
    logic [DATA_W-1:0] erd;
    pend  = cmd_q.size() > 0;
    ewe   = pend ? cmd_q[0].we : 1'b0;
    egv   = pend && !ewe && mem_cmd_ready;
    egw   = pend && ewe && mem_cmd_ready;
    erv   = (beats_left > 0) && mem_rvalid;
    erd   = erv ? mem_rdata : '0;
    edone = erv && (beats_left == 1);
    chk("mem_cmd_valid", mem_cmd_valid, pend);
    chk("vid_gnt", vid_gnt, egv);
    chk("wr_gnt", wr_gnt, egw);
    chk("vid_rvalid", vid_rvalid, erv);
    chk("vid_rdata", vid_rdata, erd);
    chk("vid_done", vid_done, edone);
    chk("err_stray", err_stray, err_m);
    if (pend) begin
      chk("mem_cmd_we", mem_cmd_we, ewe);
      chk("mem_cmd_addr", mem_cmd_addr, cmd_q[0].addr);
      if (ewe) chk("mem_wdata", mem_wdata, cmd_q[0].data);
    end
    if (!rst_n) begin
      chk("reset mem_cmd_we", mem_cmd_we, 0);
      chk("reset mem_cmd_addr", mem_cmd_addr, 0);
      chk("reset mem_wdata", mem_wdata, 0);
    end
    exp_vgnt_q = egv;
    exp_wgnt_q = egw;
    if (vid_gnt) begin n_vgnt++; gnt_cyc_v = cyc; gnt_addr_v = mem_cmd_addr; end
    if (wr_gnt) begin
      n_wgnt++; gnt_cyc_w = cyc; gnt_addr_w = mem_cmd_addr; gnt_wdata_w = mem_wdata;
    end
    if (vid_rvalid) begin n_rv++; last_rdata = vid_rdata; end
    if (vid_done) begin n_done++; done_cyc = cyc; done_rdata = vid_rdata; end
    if (mem_cmd_valid && mem_cmd_we) n_wvalid++;
  endtask

  task automatic update();
    bit pend, pwe, acc, idle;
    int w_old;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pend  = cmd_q.size() > 0;
    pwe   = pend ? cmd_q[0].we : 1'b0;
    acc   = pend && mem_cmd_ready;
    idle  = !pend && (beats_left == 0);
    w_old = wait_cycles;
    if (mem_rvalid && beats_left == 0) err_m = 1'b1;
    if (!wr_req || (acc && pwe)) wait_cycles = 0;
    else if (!(pend && pwe)) wait_cycles = (w_old >= WMAX) ? WMAX : w_old + 1;
    if (acc) begin
      if (!pwe) beats_left = BL;
      void'(cmd_q.pop_front());
    end else if (beats_left > 0) begin
      if (mem_rvalid) beats_left--;
    end else if (idle) begin
      if (wr_req && (w_old >= WMAX || !vid_req)) new_cmd(1'b1, wr_addr, wr_data);
      else if (vid_req) new_cmd(1'b0, vid_addr, '0);
    end
    if (pend && !acc) cmd_age++;
  endtask

  task automatic drive();
    if (!(vid_req && !exp_vgnt_q)) begin
      vid_req  = vid_hold || vid_once || ($urandom_range(0, 99) < vid_pct);
      vid_addr = vid_fixed ? vid_fixed_addr : ADDR_W'($urandom);
      if (vid_once) req_cyc_v = cyc;
      vid_once = 1'b0;
    end
    if (!(wr_req && !exp_wgnt_q)) begin
      wr_req  = wr_hold || wr_once || ($urandom_range(0, 99) < wr_pct);
      wr_addr = wr_fixed ? wr_fixed_addr : ADDR_W'($urandom);
      wr_data = wr_fixed ? wr_fixed_data : DATA_W'($urandom);
      wr_once = 1'b0;
    end
    if (cmd_q.size() > 0) mem_cmd_ready = (cmd_age >= ready_after);
    else mem_cmd_ready = 1'($urandom_range(0, 1));
    mem_rdata = DATA_W'($urandom);
    if (beats_left > 0) begin
      mem_rvalid = ($urandom_range(0, 99) < rv_pct);
      if (seq_mode) mem_rdata = seq_base + DATA_W'(BL - beats_left);
    end else if (rst_n && stray_n > 0) begin
      mem_rvalid = 1'b1;
      stray_n--;
    end else begin
      mem_rvalid = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    update();
    cyc++;
    #1;
    drive();
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    vid_req = 1'b0;
    wr_req  = 1'b0;
    model_reset();
    #1;
    chk("reset err_stray", err_stray, 0);
    chk("reset mem_cmd_valid", mem_cmd_valid, 0);
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    vid_pct = 0; wr_pct = 0; vid_hold = 1'b0; wr_hold = 1'b0; rv_pct = 100;
    for (int i = 0; i < 600; i++) begin
      if (!vid_req && !wr_req && cmd_q.size() == 0 && beats_left == 0) return;
      tick();
    end
    n_cmp++;
    n_bad++;
    $display("FAIL drain timeout @cycle %0d: got busy expected idle", cyc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, w0, r0, d0, wv0;
    rst_n = 1'b0;
    vid_req = 1'b0; wr_req = 1'b0; mem_cmd_ready = 1'b0; mem_rvalid = 1'b0;
    vid_addr = '0; wr_addr = '0; wr_data = '0; mem_rdata = '0;
    vid_pct = 0; wr_pct = 0; rv_pct = 100; fixed_delay = -1; stray_n = 0;
    vid_hold = 0; wr_hold = 0; vid_once = 0; wr_once = 0;
    seq_mode = 0; vid_fixed = 0; wr_fixed = 0;
    seq_base = '0; wr_fixed_data = '0; vid_fixed_addr = '0; wr_fixed_addr = '0;
    cyc = 0; n_cmp = 0; n_bad = 0; n_vgnt = 0; n_wgnt = 0; n_rv = 0; n_done = 0; n_wvalid = 0;
    gnt_cyc_v = 0; gnt_cyc_w = 0; done_cyc = 0; req_cyc_v = 0;
    exp_vgnt_q = 0; exp_wgnt_q = 0;
    model_reset();
    apply_reset(3);

    // Random traffic, no strays.
    vid_pct = 30; wr_pct = 25; rv_pct = 70; fixed_delay = -1;
    repeat (3000) tick();
    drain();

    // T1: lone video burst, ready after 3 valid cycles, sequential data.
    fixed_delay = 3; seq_mode = 1; seq_base = 16'hA000;
    vid_fixed = 1; vid_fixed_addr = 24'h000100;
    v0 = n_vgnt; r0 = n_rv; d0 = n_done; vid_once = 1;
    for (int i = 0; i < 40 && n_done == d0; i++) tick();
    chk("T1 grants", n_vgnt - v0, 1);
    chk("T1 beats", n_rv - r0, 8);
    chk("T1 cmd addr", gnt_addr_v, 24'h000100);
    chk("T1 done data", done_rdata, 16'hA007);
    chk("T1 last data", last_rdata, 16'hA007);
    chk("T1 gnt latency", gnt_cyc_v - req_cyc_v, 4);
    chk("T1 done latency", done_cyc - req_cyc_v, 12);
    drain();

    // T2: simultaneous requests, ready always.
    seq_mode = 0; vid_fixed = 0; fixed_delay = 0;
    v0 = n_vgnt; w0 = n_wgnt; vid_once = 1; wr_once = 1;
    for (int i = 0; i < 60 && n_wgnt == w0; i++) tick();
    chk("T2 video grants", n_vgnt - v0, 1);
    chk("T2 write grants", n_wgnt - w0, 1);
    chk("T2 video first", gnt_cyc_v < gnt_cyc_w, 1);
    chk("T2 write slot", gnt_cyc_w - done_cyc, 2);
    drain();

    // T3: both held; the write must break in after 7 bursts.
    fixed_delay = 0;
    v0 = n_vgnt; w0 = n_wgnt; vid_hold = 1; wr_hold = 1;
    for (int i = 0; i < 200 && n_wgnt == w0; i++) tick();
    chk("T3 video bursts before write", n_vgnt - v0, 7);
    chk("T3 write grants", n_wgnt - w0, 1);
    for (int i = 0; i < 20 && n_vgnt == v0 + 7; i++) tick();
    chk("T3 video resumes", n_vgnt - v0, 8);
    chk("T3 resume gap", gnt_cyc_v - gnt_cyc_w, 2);
    drain();

    // T6: write held off by ready low for 20 cycles.
    fixed_delay = 20; wr_fixed = 1; wr_fixed_addr = 24'h00ABCD; wr_fixed_data = 16'h5A5A;
    w0 = n_wgnt; wv0 = n_wvalid; wr_once = 1;
    for (int i = 0; i < 60 && n_wgnt == w0; i++) tick();
    chk("T6 write grants", n_wgnt - w0, 1);
    chk("T6 valid cycles", n_wvalid - wv0, 21);
    chk("T6 addr", gnt_addr_w, 24'h00ABCD);
    chk("T6 wdata", gnt_wdata_w, 16'h5A5A);
    wr_fixed = 0;
    drain();

    // T4: stray beat while idle.
    fixed_delay = -1; r0 = n_rv; stray_n = 1;
    repeat (7) tick();
    chk("T4 err sticky", err_stray, 1);
    chk("T4 no video beat", n_rv - r0, 0);

    // T5: reset after beat 3, leftover beats afterwards, then a clean burst.
    seq_mode = 1; seq_base = 16'hB000; fixed_delay = 0; rv_pct = 100;
    r0 = n_rv; vid_once = 1;
    for (int i = 0; i < 40 && (n_rv - r0) < 3; i++) tick();
    stray_n = 5;
    apply_reset(2);
    repeat (8) tick();
    chk("T5 err after leftovers", err_stray, 1);
    r0 = n_rv; d0 = n_done; v0 = n_vgnt; seq_base = 16'hC000; vid_once = 1;
    for (int i = 0; i < 40 && n_done == d0; i++) tick();
    chk("T5 new burst grant", n_vgnt - v0, 1);
    chk("T5 new burst beats", n_rv - r0, 8);
    chk("T5 done data", done_rdata, 16'hC007);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
